// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 serial receiver with a two-flop input synchronizer, a
//            one-entry holding register and sticky frame/overrun flags.
//            Optional macro UART_RX_MAJORITY_EN selects 2-of-3 majority
//            sampling around each bit decision.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk_core,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_read,
  input  logic       err_clear,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  localparam logic [CNT_W-1:0] c_half = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] c_full = CNT_W'(CLKS_PER_BIT - 1);

  logic             r_sync1;
  logic             r_rxs;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_err;
  logic             r_overrun;

  logic             w_tick;
  logic             w_sample;
  logic             w_stop_tick;
  logic             w_deliver;
  logic             w_lost;
  logic             w_ferr;

  always_ff @(posedge clk_core) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
    end
  end

  assign w_tick = (r_cnt == '0);

`ifdef UART_RX_MAJORITY_EN
  // The two earlier samples are taken on the cycles just before the tick.
  logic r_smp2;
  logic r_smp1;

  always_ff @(posedge clk_core) begin
    if (reset) begin
      r_smp2 <= 1'b1;
      r_smp1 <= 1'b1;
    end else begin
      if (r_cnt == CNT_W'(2)) r_smp2 <= r_rxs;
      if (r_cnt == CNT_W'(1)) r_smp1 <= r_rxs;
    end
  end

  assign w_sample = (r_smp2 & r_smp1) | (r_smp2 & r_rxs) | (r_smp1 & r_rxs);
`else
  assign w_sample = r_rxs;
`endif

  assign w_stop_tick = (r_state == S_STOP) && w_tick;
  assign w_deliver   = w_stop_tick && w_sample && (!r_rx_valid || rx_read);
  assign w_lost      = w_stop_tick && w_sample && r_rx_valid && !rx_read;
  assign w_ferr      = w_stop_tick && !w_sample;

  always_ff @(posedge clk_core) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      if (!w_tick) r_cnt <= r_cnt - CNT_W'(1);
      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            r_state <= S_START;
            r_cnt   <= c_half;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (!w_sample) begin
              r_state <= S_DATA;
              r_cnt   <= c_full;
              r_idx   <= 3'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= {w_sample, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            r_cnt   <= c_full;
            if (r_idx == 3'd7) r_state <= S_STOP;
          end
        end
        S_STOP: begin
          // Leaving at mid-stop-bit keeps a back-to-back start edge visible.
          if (w_tick) r_state <= w_sample ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          if (r_rxs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_core) begin
    if (reset) begin
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_deliver) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (rx_read) begin
        r_rx_valid <= 1'b0;
      end
      // A flag being set outranks a clear in the same cycle.
      if (w_ferr)         r_frame_err <= 1'b1;
      else if (err_clear) r_frame_err <= 1'b0;
      if (w_lost)         r_overrun   <= 1'b1;
      else if (err_clear) r_overrun   <= 1'b0;
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Scoreboard bench for uart_rx: directed frames plus randomized
//            traffic against a frame-level model of the holding register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
  localparam int C = 8;

  logic       clk_core = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_read;
  logic       err_clear;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  logic       mv;
  logic [7:0] m_data;
  logic       e_ferr;
  logic       e_ovr;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk_core (clk_core),
    .reset    (reset),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_read  (rx_read),
    .err_clear(err_clear),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk_core = ~clk_core;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a delivery is a rising rx_valid, or rx_valid held through a read.
  initial begin
    logic prev_valid;
    logic rd;
    logic rs;
    prev_valid = 1'b0;
    forever begin
      @(posedge clk_core);
      rd = rx_read;
      rs = reset;
      #1;
      if (!rs && rx_valid && (!prev_valid || rd)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_delivery: got %0h, expected none", rx_data);
        end else begin
          chk("delivered_byte", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_valid = rx_valid;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int gbit, input int goff);
    @(negedge clk_core);
    rx = 1'b0;
    repeat (C) @(negedge clk_core);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < C; k++) begin
        rx = (i == gbit && k == goff) ? ~b[i] : b[i];
        @(negedge clk_core);
      end
    end
    rx = stop_v;
    repeat (C) @(negedge clk_core);
  endtask

  // Model of a frame with a good stop bit and no coincident read.
  task automatic expect_good(input logic [7:0] b);
    if (!mv) begin
      exp_q.push_back(b);
      mv     = 1'b1;
      m_data = b;
    end else begin
      e_ovr = 1'b1;
    end
  endtask

  task automatic do_read();
    @(negedge clk_core);
    rx_read = 1'b1;
    @(negedge clk_core);
    rx_read = 1'b0;
    mv = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk_core);
    err_clear = 1'b1;
    @(negedge clk_core);
    err_clear = 1'b0;
    e_ferr = 1'b0;
    e_ovr  = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic exp_busy);
    chk({tag, "_valid"}, {31'd0, rx_valid}, {31'd0, mv});
    chk({tag, "_frame_err"}, {31'd0, frame_err}, {31'd0, e_ferr});
    chk({tag, "_overrun"}, {31'd0, overrun}, {31'd0, e_ovr});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
    if (mv) chk({tag, "_data"}, {24'd0, rx_data}, {24'd0, m_data});
  endtask

  initial begin
    logic [7:0] b;
    logic       ok;
    reset = 1'b1; rx = 1'b1; rx_read = 1'b0; err_clear = 1'b0;
    mv = 1'b0; m_data = 8'h00; e_ferr = 1'b0; e_ovr = 1'b0;
    repeat (4) @(negedge clk_core);
    chk("reset_data", {24'd0, rx_data}, 32'h0);
    check_state("reset", 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk_core);

    // 0x55 with latency check: valid rises at edge 79, busy drops at the same edge.
    expect_good(8'h55);
    fork
      send_frame(8'h55, 1'b1, -1, 0);
      begin
        @(negedge clk_core);
        repeat (78) @(posedge clk_core);
        #1;
        chk("lat_valid_e78", {31'd0, rx_valid}, 32'd0);
        chk("lat_busy_e78", {31'd0, busy}, 32'd1);
        @(posedge clk_core);
        #1;
        chk("lat_valid_e79", {31'd0, rx_valid}, 32'd1);
        chk("lat_busy_e79", {31'd0, busy}, 32'd0);
      end
    join
    check_state("f55", 1'b0);
    do_read();

    // Back-to-back without read: overrun, first byte kept.
    expect_good(8'hA3);
    send_frame(8'hA3, 1'b1, -1, 0);
    expect_good(8'h0F);
    send_frame(8'h0F, 1'b1, -1, 0);
    check_state("ovr", 1'b0);
    do_clear();
    check_state("ovr_clr", 1'b0);

    // Stop tick of the next frame coincides with the read of the held byte.
    exp_q.push_back(8'h5A);
    fork
      send_frame(8'h5A, 1'b1, -1, 0);
      begin
        @(negedge clk_core);
        repeat (78) @(negedge clk_core);
        rx_read = 1'b1;
        @(negedge clk_core);
        rx_read = 1'b0;
      end
    join
    m_data = 8'h5A;
    check_state("coinc", 1'b0);
    do_read();

    // Bad stop bit with the line held low: frame error, parked in BREAK.
    send_frame(8'h3C, 1'b0, -1, 0);
    e_ferr = 1'b1;
    repeat (40) @(negedge clk_core);
    check_state("brk", 1'b1);
    rx = 1'b1;
    repeat (4) @(negedge clk_core);
    check_state("brk_exit", 1'b0);
    expect_good(8'h81);
    send_frame(8'h81, 1'b1, -1, 0);
    check_state("f81", 1'b0);
    do_read();
    do_clear();

    // 3-cycle low glitch in idle: false start, nothing reported.
    @(negedge clk_core);
    rx = 1'b0;
    repeat (3) @(negedge clk_core);
    rx = 1'b1;
    repeat (20) @(negedge clk_core);
    check_state("glitch_idle", 1'b0);

    // 1-cycle glitch at the decision point of data bit 2 of 0x00.
`ifdef UART_RX_MAJORITY_EN
    expect_good(8'h00);
`else
    expect_good(8'h04);
`endif
    send_frame(8'h00, 1'b1, 2, 4);
    check_state("midglitch", 1'b0);
    do_read();

    // Reset in data bit 4 aborts the frame.
    fork
      send_frame(8'hFF, 1'b1, -1, 0);
      begin
        @(negedge clk_core);
        repeat (44) @(negedge clk_core);
        reset = 1'b1;
        repeat (2) @(negedge clk_core);
        reset = 1'b0;
        mv = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0;
      end
    join
    check_state("abort", 1'b0);
    chk("abort_data", {24'd0, rx_data}, 32'h0);
    expect_good(8'h12);
    send_frame(8'h12, 1'b1, -1, 0);
    check_state("f12", 1'b0);
    do_read();

    // Randomized traffic.
    for (int n = 0; n < 16; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      repeat ($urandom_range(0, 12)) @(negedge clk_core);
      if (ok) begin
        expect_good(b);
        send_frame(b, 1'b1, -1, 0);
      end else begin
        send_frame(b, 1'b0, -1, 0);
        e_ferr = 1'b1;
        rx = 1'b1;
        repeat (4) @(negedge clk_core);
      end
      check_state("rand", 1'b0);
      if ($urandom_range(0, 3) != 0) do_read();
      if ($urandom_range(0, 4) == 0) do_clear();
    end

    repeat (4) @(negedge clk_core);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
